joystick_move_cmd: RTL and testbench

//  Sits directly downstream of the joystick direction stage. Consumes its 4-bit direction

---
 rtl/joystick_move_cmd.sv | 158 +++++++++++++++
 tb/tb_joystick_move_cmd.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_move_cmd.sv
// Debounced single-direction move commands with valid/ready handshake, driven by the joystick direction vector.
// Optional macro JOYSTICK_AUTO_REPEAT_EN adds DELAY/REPEAT auto-repeat; otherwise one command per press (HOLD).
module joystick_move_cmd #(
  parameter int INPUT_FREQ      = 100_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_MS       = 150
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dir_in,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_dir,
  output logic       held,
  output logic [1:0] state_dbg
);
  // Handshake: a command is transferred in every cycle where cmd_valid && cmd_ready;
  // once raised, cmd_valid stays high and cmd_dir stays constant until that transfer.

  localparam int CLKS_PER_MS = INPUT_FREQ / 1000;
  localparam int MS_W        = $clog2(CLKS_PER_MS);
  localparam int MAX_AB      = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int MAX_MS      = (MAX_AB > REPEAT_MS) ? MAX_AB : REPEAT_MS;
  localparam int CNT_W       = $clog2(MAX_MS + 1);

  localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(CLKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_MS);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2, HOLD = 2'd3} state_t;

`ifdef JOYSTICK_AUTO_REPEAT_EN
  localparam state_t           FIRST      = DELAY;
  localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY_MS);
  localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_MS);
  localparam logic [CNT_W-1:0] REP_SAT    = CNT_W'(MAX_MS);
  logic [CNT_W-1:0] rep_cnt;
`else
  localparam state_t FIRST = HOLD;
`endif

  logic [MS_W-1:0]  ms_cnt;
  logic             ms_tick;
  logic [3:0]       sync1, sync2;
  logic [2:0]       res;       // {valid, dir}; 3'b000 means NONE
  logic [2:0]       cand, stable;
  logic [CNT_W-1:0] db_cnt;
  state_t           state_q, state_d;
  logic             enter, issue;
  logic [1:0]       act_dir;

  assign ms_tick = (ms_cnt == MS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt <= '0;
      sync1  <= '0;
      sync2  <= '0;
    end else begin
      ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
      sync1  <= dir_in;
      sync2  <= sync1;
    end
  end

  always_comb begin
    res = 3'b000;
    case (sync2)
      4'b0001: res = 3'b100;
      4'b0010: res = 3'b101;
      4'b0100: res = 3'b110;
      4'b1000: res = 3'b111;
      default: res = 3'b000;
    endcase
  end

  // Any change of the resolved value restarts the debounce window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand   <= 3'b000;
      db_cnt <= '0;
      stable <= 3'b000;
      held   <= 1'b0;
    end else begin
      held <= stable[2];
      if (res != cand) begin
        cand   <= res;
        db_cnt <= '0;
      end else begin
        if (ms_tick && db_cnt != DB_TARGET) db_cnt <= db_cnt + 1'b1;
        if (db_cnt == DB_TARGET) stable <= cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      act_dir <= 2'b00;
`ifdef JOYSTICK_AUTO_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (issue) act_dir <= stable[1:0];
`ifdef JOYSTICK_AUTO_REPEAT_EN
      if (enter) rep_cnt <= '0;
      else if (ms_tick && rep_cnt != REP_SAT) rep_cnt <= rep_cnt + 1'b1;
`endif
    end
  end

  // enter marks every state entry, including re-entry of REPEAT.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    if (state_q == IDLE) begin
      if (stable[2]) begin
        state_d = FIRST;
        enter   = 1'b1;
      end
    end else if (!stable[2]) begin
      state_d = IDLE;
      enter   = 1'b1;
    end else if (stable[1:0] != act_dir) begin
      state_d = FIRST;
      enter   = 1'b1;
    end
`ifdef JOYSTICK_AUTO_REPEAT_EN
    else if (state_q == DELAY && rep_cnt == REP_DELAY) begin
      state_d = REPEAT;
      enter   = 1'b1;
    end else if (state_q == REPEAT && rep_cnt == REP_PERIOD) begin
      state_d = REPEAT;
      enter   = 1'b1;
    end
`endif
  end

  always_comb begin
    issue     = enter && (state_d != IDLE);
    state_dbg = state_q;
  end

  // An issue that meets a stalled command is dropped; the pending one is untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_dir   <= 2'b00;
    end else if (issue && (!cmd_valid || cmd_ready)) begin
      cmd_valid <= 1'b1;
      cmd_dir   <= stable[1:0];
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_joystick_move_cmd.sv
// Directed bench for joystick_move_cmd at 10 clk/ms, DEBOUNCE_MS=2, REPEAT_DELAY_MS=5, REPEAT_MS=3.
module tb_joystick_move_cmd;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] dir_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic       held;
  logic [1:0] state_dbg;

  joystick_move_cmd #(
    .INPUT_FREQ(10_000), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(5), .REPEAT_MS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .held(held), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  logic       pv, pr;
  logic [1:0] pd;
  int         acc_cnt  = 0;
  logic [1:0] acc_q[$];
  int         acc_t[$];
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pv && !pr) begin
        check("pending_valid_kept", int'(cmd_valid), 1);
        check("pending_dir_kept", int'(cmd_dir), int'(pd));
      end
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        acc_q.push_back(cmd_dir);
        acc_t.push_back(cyc);
      end
      pv = cmd_valid; pr = cmd_ready; pd = cmd_dir;
    end else begin
      pv = 1'b0; pr = 1'b0; pd = 2'b00;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      step();
      n++;
      if (cmd_valid) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0] dir;
    int         hold;
    int         exp_cmds;
    logic [1:0] exp_dir;
    logic       exp_held;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int  n, a0, t1, seen_v, seen_h;
    bit  ok;

    vecs[0] = '{4'b0001, 32, 1, 2'b00, 1'b1};
    vecs[1] = '{4'b0010, 32, 1, 2'b01, 1'b1};
    vecs[2] = '{4'b0100, 32, 1, 2'b10, 1'b1};
    vecs[3] = '{4'b1000, 32, 1, 2'b11, 1'b1};
    vecs[4] = '{4'b0101, 100, 0, 2'b00, 1'b0};
    vecs[5] = '{4'b1111, 100, 0, 2'b00, 1'b0};
    vecs[6] = '{4'b0001, 8, 0, 2'b00, 1'b0};
    vecs[7] = '{4'b0011, 100, 0, 2'b00, 1'b0};

    // Reset held with a direction present
    reset_n = 1'b0; dir_in = 4'b0001; cmd_ready = 1'b1;
    seen_v = 0; seen_h = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cmd_valid || cmd_dir != 2'b00) seen_v++;
      if (held) seen_h++;
    end
    check("reset_cmd_quiet", seen_v, 0);
    check("reset_held_low", seen_h, 0);
    check("reset_state_idle", int'(state_dbg), 0);

    reset_n = 1'b1; mon_en = 1'b1;
    wait_valid(100, n, ok);
    check("first_cmd_seen", int'(ok), 1);
    check_range("first_cmd_latency", n, 22, 32);
    check("first_cmd_dir", int'(cmd_dir), 0);
    check("first_held", int'(held), 1);
    step();
    check("first_cmd_pulse", int'(cmd_valid), 0);

    dir_in = 4'b0000;
    n = 0;
    while (n < 60 && held) begin step(); n++; end
    check_range("release_held_latency", n, 12, 32);
    step();
    check("release_no_extra_cmd", acc_cnt, 1);

    // Bouncing input never settles
    a0 = acc_cnt; seen_h = 0;
    for (int i = 0; i < 40; i++) begin
      dir_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int j = 0; j < 5; j++) begin step(); if (held) seen_h++; end
    end
    dir_in = 4'b0000;
    for (int i = 0; i < 40; i++) begin step(); if (held) seen_h++; end
    check("bounce_no_cmd", acc_cnt - a0, 0);
    check("bounce_held_low", seen_h, 0);

    // Table of single presses
    foreach (vecs[k]) begin
      a0 = acc_cnt;
      dir_in = vecs[k].dir;
      repeat (vecs[k].hold) step();
      check($sformatf("vec%0d_held", k), int'(held), int'(vecs[k].exp_held));
      dir_in = 4'b0000;
      repeat (60) step();
      check($sformatf("vec%0d_cmds", k), acc_cnt - a0, vecs[k].exp_cmds);
      if (vecs[k].exp_cmds > 0)
        check($sformatf("vec%0d_dir", k), int'(acc_q[acc_q.size()-1]), int'(vecs[k].exp_dir));
      check($sformatf("vec%0d_released", k), int'(held), 0);
    end

    // Auto-repeat while right is held
    acc_q.delete(); acc_t.delete();
    dir_in = 4'b1000;
    wait_valid(60, n, ok);
    check("rep_first_seen", int'(ok), 1);
    repeat (205) step();
    check("rep_held", int'(held), 1);
`ifdef JOYSTICK_AUTO_REPEAT_EN
    repeat (7) exp_q.push_back(2'b11);
`else
    exp_q.push_back(2'b11);
`endif
    check("rep_count", acc_q.size(), exp_q.size());
    while (exp_q.size() > 0 && acc_q.size() > 0)
      check("rep_dir", int'(acc_q.pop_front()), int'(exp_q.pop_front()));
    exp_q.delete();
`ifdef JOYSTICK_AUTO_REPEAT_EN
    for (int i = 1; i < acc_t.size(); i++) begin
      if (i == 1) check_range("rep_first_gap", acc_t[1] - acc_t[0], 41, 51);
      else        check_range("rep_gap", acc_t[i] - acc_t[i-1], 29, 31);
    end
`endif
    dir_in = 4'b0000;
    repeat (60) step();

    // Stalled consumer: repeats dropped, one handshake
    cmd_ready = 1'b0; a0 = acc_cnt;
    dir_in = 4'b0100;
    wait_valid(60, n, ok);
    check("stall_first_seen", int'(ok), 1);
    check("stall_dir", int'(cmd_dir), 2);
    repeat (120) step();
    check("stall_still_valid", int'(cmd_valid), 1);
    check("stall_still_dir", int'(cmd_dir), 2);
    for (int i = 0; i < 10 && (cyc % 10) != 4; i++) step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("stall_one_handshake", acc_cnt - a0, 1);
    check("stall_valid_dropped", int'(cmd_valid), 0);
`ifdef JOYSTICK_AUTO_REPEAT_EN
    wait_valid(40, n, ok);
    check("stall_next_repeat", int'(ok), 1);
    check("stall_repeat_dir", int'(cmd_dir), 2);
`else
    seen_v = 0;
    for (int i = 0; i < 40; i++) begin step(); if (cmd_valid) seen_v++; end
    check("stall_no_repeat", seen_v, 0);
`endif
    cmd_ready = 1'b1;
    step(); step();
    dir_in = 4'b0000;
    repeat (60) step();

    // Diagonal, then left, then straight to up
    a0 = acc_cnt; seen_h = 0;
    dir_in = 4'b0101;
    for (int i = 0; i < 100; i++) begin step(); if (held) seen_h++; end
    check("diag_no_cmd", acc_cnt - a0, 0);
    check("diag_held_low", seen_h, 0);
    dir_in = 4'b0100;
    wait_valid(60, n, ok);
    check("diag_left_seen", int'(ok), 1);
    check("diag_left_dir", int'(cmd_dir), 2);
    repeat (5) step();
    dir_in = 4'b0001;
    wait_valid(60, n, ok);
    check("change_up_seen", int'(ok), 1);
    check("change_up_dir", int'(cmd_dir), 0);
    t1 = cyc;
`ifdef JOYSTICK_AUTO_REPEAT_EN
    wait_valid(60, n, ok);
    check("change_repeat_seen", int'(ok), 1);
    check_range("change_delay_restart", cyc - t1, 41, 51);
    check("change_repeat_dir", int'(cmd_dir), 0);
`else
    seen_v = 0;
    for (int i = 0; i < 80; i++) begin step(); if (cmd_valid) seen_v++; end
    check("change_no_repeat", seen_v, 0);
`endif
    dir_in = 4'b0000;
    repeat (60) step();

    // Pending command survives IDLE, then is lost on reset
    cmd_ready = 1'b0;
    dir_in = 4'b0010;
    wait_valid(60, n, ok);
    check("survive_seen", int'(ok), 1);
    dir_in = 4'b0000;
    repeat (60) step();
    check("survive_held_low", int'(held), 0);
    check("survive_state_idle", int'(state_dbg), 0);
    check("survive_valid", int'(cmd_valid), 1);
    check("survive_dir", int'(cmd_dir), 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", int'(cmd_valid), 0);
    check("async_reset_dir", int'(cmd_dir), 0);
    check("async_reset_state", int'(state_dbg), 0);
    repeat (3) step();
    reset_n = 1'b1; cmd_ready = 1'b1; mon_en = 1'b1;
    a0 = acc_cnt;
    repeat (60) step();
    check("post_reset_quiet", acc_cnt - a0, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
